// File: rtl/toy_bus_dec_pkg.sv
// Shared definitions for the toy bus decoder node: field widths, opcodes and
// the fixed-width headers of the request/ack payloads.
package toy_bus_dec_pkg;

   localparam int ADDR_W = 32;
   localparam int SB_W   = 32;

   localparam logic OPC_RD = 1'b0;
   localparam logic OPC_WR = 1'b1;

   // Opcode carried by acks produced by the local error responder
   localparam logic OPC_ERR_ACK = OPC_WR;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              opcode;
      logic [SB_W-1:0]   sideband;
   } req_hdr_t;

   typedef struct packed {
      logic            opcode;
      logic [SB_W-1:0] sideband;
   } ack_hdr_t;

endpackage

// File: rtl/toy_bus_rr_arb.sv
// Lock-free round-robin arbiter. The search starts at the stored pointer; when
// the consumer takes a grant (adv), the pointer moves to one past the winner.
module toy_bus_rr_arb #(
   parameter int N     = 5,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             adv,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
      int s;
      s = 32'(a) + b;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   // First requester found walking the ring from the pointer wins
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      for (int i = 0; i < N; i++) begin
         if (!gnt_vld && req[wrap_add(ptr_q, i)]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap_add(ptr_q, i);
         end
      end
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
      ptr_d = (adv && gnt_vld) ? wrap_add(gnt_idx, 1) : ptr_q;
   end

   // Pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/toy_bus_dec_node_nch.sv
// Toy bus decoder node: routes one request channel to N_OUT targets by tgt_id,
// limits outstanding requests per target, answers illegal targets locally and
// merges target acks round-robin into a one-entry registered ack stage.
// Optional: TOY_BUS_DEC_REQ_SKID_EN adds a 2-entry skid buffer on the request input.
module toy_bus_dec_node_nch
   import toy_bus_dec_pkg::*;
#(
   parameter int N_OUT     = 4,
   parameter int DATA_W    = 256,
   parameter int ID_W      = 4,
   parameter int MAX_OUTST = 8,
   parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_req_vld,
   output logic                       in_req_rdy,
   input  logic [ADDR_W-1:0]          in_req_addr,
   input  logic [DATA_W/8-1:0]        in_req_strb,
   input  logic [DATA_W-1:0]          in_req_data,
   input  logic                       in_req_opcode,
   input  logic [ID_W-1:0]            in_req_src_id,
   input  logic [ID_W-1:0]            in_req_tgt_id,
   input  logic [SB_W-1:0]            in_req_sideband,
   output logic                       in_ack_vld,
   input  logic                       in_ack_rdy,
   output logic                       in_ack_opcode,
   output logic [DATA_W-1:0]          in_ack_data,
   output logic [SB_W-1:0]            in_ack_sideband,
   output logic [ID_W-1:0]            in_ack_src_id,
   output logic [ID_W-1:0]            in_ack_tgt_id,
   output logic [N_OUT-1:0]           out_req_vld,
   input  logic [N_OUT-1:0]           out_req_rdy,
   output logic [N_OUT*ADDR_W-1:0]    out_req_addr,
   output logic [N_OUT*DATA_W/8-1:0]  out_req_strb,
   output logic [N_OUT*DATA_W-1:0]    out_req_data,
   output logic [N_OUT-1:0]           out_req_opcode,
   output logic [N_OUT*ID_W-1:0]      out_req_src_id,
   output logic [N_OUT*ID_W-1:0]      out_req_tgt_id,
   output logic [N_OUT*SB_W-1:0]      out_req_sideband,
   input  logic [N_OUT-1:0]           out_ack_vld,
   output logic [N_OUT-1:0]           out_ack_rdy,
   input  logic [N_OUT-1:0]           out_ack_opcode,
   input  logic [N_OUT*DATA_W-1:0]    out_ack_data,
   input  logic [N_OUT*SB_W-1:0]      out_ack_sideband,
   input  logic [N_OUT*ID_W-1:0]      out_ack_src_id,
   input  logic [N_OUT*ID_W-1:0]      out_ack_tgt_id,
   output logic [N_OUT*CNT_W-1:0]     outst_cnt
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = $clog2(N_OUT);
   localparam int ARB_N  = N_OUT + 1;
   localparam int ARB_W  = $clog2(ARB_N);

   typedef struct packed {
      req_hdr_t          hdr;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
   } req_t;

   typedef struct packed {
      ack_hdr_t          hdr;
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
   } ack_t;

   req_t             in_pkt, h;
   logic             h_vld, h_rdy;
   logic             legal, err_take;
   logic [IDX_W-1:0] tgt_idx;
   logic [N_OUT-1:0] inc, dec;
   logic [CNT_W-1:0] cnt_q [N_OUT];
   logic [CNT_W-1:0] cnt_d [N_OUT];
   logic             err_pend_q, err_pend_d;
   logic [ID_W-1:0]  err_src_q, err_src_d, err_tgt_q, err_tgt_d;
   logic [SB_W-1:0]  err_sb_q, err_sb_d;
   logic [ARB_N-1:0] arb_req, arb_gnt;
   logic [ARB_W-1:0] arb_idx;
   logic             arb_vld, ld_ok, ack_ld;
   logic             ack_vld_q, ack_vld_d;
   ack_t             ack_q, ack_d, ack_sel;

   // Pack the upstream request fields into one payload
   always_comb begin
      in_pkt.hdr.addr     = in_req_addr;
      in_pkt.hdr.opcode   = in_req_opcode;
      in_pkt.hdr.sideband = in_req_sideband;
      in_pkt.strb         = in_req_strb;
      in_pkt.data         = in_req_data;
      in_pkt.src_id       = in_req_src_id;
      in_pkt.tgt_id       = in_req_tgt_id;
   end

`ifdef TOY_BUS_DEC_REQ_SKID_EN
   req_t       sk_q [2];
   req_t       sk_d [2];
   logic       rp_q, rp_d, wp_q, wp_d, rdy_q, rdy_d, push, pop;
   logic [1:0] fill_q, fill_d;

   // Skid bookkeeping: push on upstream handshake, pop when the decoder takes the head
   always_comb begin
      push = in_req_vld && rdy_q;
      pop  = h_vld && h_rdy;
      sk_d = sk_q;
      if (push) sk_d[wp_q] = in_pkt;
      wp_d   = wp_q ^ push;
      rp_d   = rp_q ^ pop;
      fill_d = fill_q + {1'b0, push} - {1'b0, pop};
      rdy_d  = (fill_d != 2'd2);
   end

   assign h_vld      = (fill_q != 2'd0);
   assign h          = sk_q[rp_q];
   assign in_req_rdy = rdy_q;

   // Skid control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_q   <= 1'b0;
         wp_q   <= 1'b0;
         fill_q <= 2'd0;
         rdy_q  <= 1'b1;
      end else begin
         rp_q   <= rp_d;
         wp_q   <= wp_d;
         fill_q <= fill_d;
         rdy_q  <= rdy_d;
      end
   end

   // Skid payload storage; only meaningful while counted in fill_q
   always_ff @(posedge clk) begin
      sk_q <= sk_d;
   end
`else
   assign h_vld      = in_req_vld;
   assign h          = in_pkt;
   assign in_req_rdy = h_rdy;
`endif

   // Decode the head request: route to a target with room, or take it locally when illegal
   always_comb begin
      tgt_idx     = h.tgt_id[IDX_W-1:0];
      legal       = (32'(h.tgt_id) < 32'(N_OUT));
      out_req_vld = '0;
      h_rdy       = 1'b0;
      err_take    = 1'b0;
      if (legal) begin
         if (cnt_q[tgt_idx] != CNT_W'(MAX_OUTST)) begin
            out_req_vld[tgt_idx] = h_vld;
            h_rdy                = out_req_rdy[tgt_idx];
         end
      end else begin
         h_rdy    = !err_pend_q;
         err_take = h_vld && !err_pend_q;
      end
   end

   assign out_req_addr     = {N_OUT{h.hdr.addr}};
   assign out_req_strb     = {N_OUT{h.strb}};
   assign out_req_data     = {N_OUT{h.data}};
   assign out_req_opcode   = {N_OUT{h.hdr.opcode}};
   assign out_req_src_id   = {N_OUT{h.src_id}};
   assign out_req_tgt_id   = {N_OUT{h.tgt_id}};
   assign out_req_sideband = {N_OUT{h.hdr.sideband}};

   assign inc = out_req_vld & out_req_rdy;
   assign dec = out_ack_vld & out_ack_rdy;

   // Outstanding counters: +1 on request, -1 on ack, saturating at zero
   always_comb begin
      for (int p = 0; p < N_OUT; p++) begin
         cnt_d[p] = cnt_q[p];
         if (inc[p] && !dec[p])
            cnt_d[p] = cnt_q[p] + CNT_W'(1);
         else if (!inc[p] && dec[p] && cnt_q[p] != '0)
            cnt_d[p] = cnt_q[p] - CNT_W'(1);
      end
   end

   for (genvar p = 0; p < N_OUT; p++) begin : g_cnt
      assign outst_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
      a_ack_underflow: assert property (@(posedge clk) disable iff (!rst_n)
         !(dec[p] && cnt_q[p] == '0));
   end

   assign arb_req     = {err_pend_q, out_ack_vld};
   assign ld_ok       = !ack_vld_q || in_ack_rdy;
   assign ack_ld      = arb_vld && ld_ok;
   assign out_ack_rdy = ld_ok ? arb_gnt[N_OUT-1:0] : '0;

   toy_bus_rr_arb #(
      .N     (ARB_N),
      .IDX_W (ARB_W)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (arb_req),
      .adv     (ld_ok),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // Select the granted ack payload; the error responder is the default slot
   always_comb begin
      ack_sel.hdr.opcode   = OPC_ERR_ACK;
      ack_sel.hdr.sideband = err_sb_q;
      ack_sel.data         = '0;
      ack_sel.src_id       = err_src_q;
      ack_sel.tgt_id       = err_tgt_q;
      for (int p = 0; p < N_OUT; p++) begin
         if (arb_gnt[p]) begin
            ack_sel.hdr.opcode   = out_ack_opcode[p];
            ack_sel.hdr.sideband = out_ack_sideband[p*SB_W +: SB_W];
            ack_sel.data         = out_ack_data[p*DATA_W +: DATA_W];
            ack_sel.src_id       = out_ack_src_id[p*ID_W +: ID_W];
            ack_sel.tgt_id       = out_ack_tgt_id[p*ID_W +: ID_W];
         end
      end
      ack_vld_d = ld_ok ? arb_vld : ack_vld_q;
      ack_d     = ack_ld ? ack_sel : ack_q;
   end

   // Error responder: capture an illegal request, release on its ack grant
   always_comb begin
      err_pend_d = err_pend_q;
      err_src_d  = err_src_q;
      err_tgt_d  = err_tgt_q;
      err_sb_d   = err_sb_q;
      if (err_take) begin
         err_pend_d = 1'b1;
         err_src_d  = h.tgt_id;
         err_tgt_d  = h.src_id;
         err_sb_d   = h.hdr.sideband;
      end else if (ack_ld && arb_gnt[N_OUT]) begin
         err_pend_d = 1'b0;
      end
   end

   // State registers for counters, error responder and ack stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < N_OUT; p++) cnt_q[p] <= '0;
         err_pend_q <= 1'b0;
         err_src_q  <= '0;
         err_tgt_q  <= '0;
         err_sb_q   <= '0;
         ack_vld_q  <= 1'b0;
         ack_q      <= '0;
      end else begin
         for (int p = 0; p < N_OUT; p++) cnt_q[p] <= cnt_d[p];
         err_pend_q <= err_pend_d;
         err_src_q  <= err_src_d;
         err_tgt_q  <= err_tgt_d;
         err_sb_q   <= err_sb_d;
         ack_vld_q  <= ack_vld_d;
         ack_q      <= ack_d;
      end
   end

   assign in_ack_vld      = ack_vld_q;
   assign in_ack_opcode   = ack_q.hdr.opcode;
   assign in_ack_sideband = ack_q.hdr.sideband;
   assign in_ack_data     = ack_q.data;
   assign in_ack_src_id   = ack_q.src_id;
   assign in_ack_tgt_id   = ack_q.tgt_id;

endmodule

// File: tb/tb_toy_bus_dec_node_nch.sv
// Directed bench for toy_bus_dec_node_nch (default build, N_OUT=4, MAX_OUTST=2).
module tb_toy_bus_dec_node_nch;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int MO = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_req_vld, in_req_rdy;
  logic [31:0]     in_req_addr;
  logic [SW-1:0]   in_req_strb;
  logic [DW-1:0]   in_req_data;
  logic            in_req_opcode;
  logic [IW-1:0]   in_req_src_id, in_req_tgt_id;
  logic [31:0]     in_req_sideband;
  logic            in_ack_vld, in_ack_rdy, in_ack_opcode;
  logic [DW-1:0]   in_ack_data;
  logic [31:0]     in_ack_sideband;
  logic [IW-1:0]   in_ack_src_id, in_ack_tgt_id;
  logic [N-1:0]    out_req_vld, out_req_rdy, out_req_opcode;
  logic [N*32-1:0] out_req_addr, out_req_sideband;
  logic [N*SW-1:0] out_req_strb;
  logic [N*DW-1:0] out_req_data;
  logic [N*IW-1:0] out_req_src_id, out_req_tgt_id;
  logic [N-1:0]    out_ack_vld, out_ack_rdy, out_ack_opcode;
  logic [N*DW-1:0] out_ack_data;
  logic [N*32-1:0] out_ack_sideband;
  logic [N*IW-1:0] out_ack_src_id, out_ack_tgt_id;
  logic [N*CW-1:0] outst_cnt;

  int n_asrt = 0;
  int n_fail = 0;

  toy_bus_dec_node_nch #(
    .N_OUT(N), .DATA_W(DW), .ID_W(IW), .MAX_OUTST(MO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy), .in_req_addr(in_req_addr),
    .in_req_strb(in_req_strb), .in_req_data(in_req_data), .in_req_opcode(in_req_opcode),
    .in_req_src_id(in_req_src_id), .in_req_tgt_id(in_req_tgt_id),
    .in_req_sideband(in_req_sideband),
    .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy), .in_ack_opcode(in_ack_opcode),
    .in_ack_data(in_ack_data), .in_ack_sideband(in_ack_sideband),
    .in_ack_src_id(in_ack_src_id), .in_ack_tgt_id(in_ack_tgt_id),
    .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy), .out_req_addr(out_req_addr),
    .out_req_strb(out_req_strb), .out_req_data(out_req_data),
    .out_req_opcode(out_req_opcode), .out_req_src_id(out_req_src_id),
    .out_req_tgt_id(out_req_tgt_id), .out_req_sideband(out_req_sideband),
    .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy),
    .out_ack_opcode(out_ack_opcode), .out_ack_data(out_ack_data),
    .out_ack_sideband(out_ack_sideband), .out_ack_src_id(out_ack_src_id),
    .out_ack_tgt_id(out_ack_tgt_id), .outst_cnt(outst_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(input string tag);
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_req_vld = 1'b0; in_req_addr = '0; in_req_strb = '1; in_req_data = '0;
    in_req_opcode = 1'b0; in_req_src_id = '0; in_req_tgt_id = '0; in_req_sideband = '0;
    in_ack_rdy = 1'b1; out_req_rdy = '1;
    out_ack_vld = '0; out_ack_opcode = '0; out_ack_data = '0; out_ack_sideband = '0;
    out_ack_src_id = '0; out_ack_tgt_id = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    n_asrt++; if (out_req_vld !== 4'b0000) fail("rst_out_req_vld");
    n_asrt++; if (in_ack_vld !== 1'b0) fail("rst_in_ack_vld");
    n_asrt++; if (in_ack_data !== 32'h0) fail("rst_in_ack_data");
    n_asrt++; if (outst_cnt !== 8'h00) fail("rst_outst_cnt");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic routing to target 2, zero latency
    in_req_vld = 1'b1; in_req_tgt_id = 4'd2; in_req_src_id = 4'd1;
    in_req_addr = 32'h100; in_req_opcode = 1'b1; in_req_data = 32'hDEADBEEF;
    in_req_sideband = 32'h55;
    #1;
    n_asrt++; if (out_req_vld !== 4'b0100) fail("route_vld");
    n_asrt++; if (in_req_rdy !== 1'b1) fail("route_rdy");
    n_asrt++; if (out_req_addr[2*32 +: 32] !== 32'h100) fail("route_addr2");
    n_asrt++; if (out_req_data[2*DW +: DW] !== 32'hDEADBEEF) fail("route_data2");
    n_asrt++; if (out_req_tgt_id[2*IW +: IW] !== 4'd2) fail("route_tgt2");
    tick();
    in_req_vld = 1'b0;
    #1;
    n_asrt++; if (outst_cnt !== 8'h10) fail("route_cnt");

    // Outstanding limit on target 1
    in_req_vld = 1'b1; in_req_tgt_id = 4'd1; in_req_addr = 32'h200;
    #1;
    n_asrt++; if (in_req_rdy !== 1'b1) fail("lim_rdy1");
    n_asrt++; if (out_req_vld !== 4'b0010) fail("lim_vld1");
    tick();
    n_asrt++; if (in_req_rdy !== 1'b1) fail("lim_rdy2");
    tick();
    n_asrt++; if (in_req_rdy !== 1'b0) fail("lim_rdy3");
    n_asrt++; if (out_req_vld !== 4'b0000) fail("lim_vld3");
    tick();
    n_asrt++; if (in_req_rdy !== 1'b0) fail("lim_hold_rdy");
    n_asrt++; if (outst_cnt !== 8'h18) fail("lim_hold_cnt");
    out_ack_vld = 4'b0010; out_ack_data[1*DW +: DW] = 32'h1111;
    #1;
    n_asrt++; if (out_ack_rdy !== 4'b0010) fail("lim_ack_rdy");
    n_asrt++; if (in_req_rdy !== 1'b0) fail("lim_rdy_during_ack");
    tick();
    out_ack_vld = 4'b0000;
    #1;
    n_asrt++; if (in_req_rdy !== 1'b1) fail("lim_rdy_after_ack");
    n_asrt++; if (out_req_vld !== 4'b0010) fail("lim_vld_after_ack");
    n_asrt++; if (in_ack_vld !== 1'b1) fail("lim_in_ack_vld");
    n_asrt++; if (in_ack_data !== 32'h1111) fail("lim_in_ack_data");
    tick();
    in_req_vld = 1'b0;
    #1;
    n_asrt++; if (outst_cnt !== 8'h18) fail("lim_cnt_final");
    n_asrt++; if (in_ack_vld !== 1'b0) fail("lim_ack_drained");

    // Illegal target answered by the local error responder
    in_req_vld = 1'b1; in_req_tgt_id = 4'd9; in_req_src_id = 4'd3;
    in_req_sideband = 32'hABCD;
    #1;
    n_asrt++; if (in_req_rdy !== 1'b1) fail("err_rdy");
    n_asrt++; if (out_req_vld !== 4'b0000) fail("err_no_vld");
    tick();
    in_req_vld = 1'b0;
    #1;
    n_asrt++; if (in_req_rdy !== 1'b0) fail("err_pend_blocks");
    n_asrt++; if (out_ack_rdy !== 4'b0000) fail("err_no_target_rdy");
    tick();
    n_asrt++; if (in_ack_vld !== 1'b1) fail("err_ack_vld");
    n_asrt++; if (in_ack_opcode !== 1'b1) fail("err_ack_opc");
    n_asrt++; if (in_ack_data !== 32'h0) fail("err_ack_data");
    n_asrt++; if (in_ack_src_id !== 4'd9) fail("err_ack_src");
    n_asrt++; if (in_ack_tgt_id !== 4'd3) fail("err_ack_tgt");
    n_asrt++; if (in_ack_sideband !== 32'hABCD) fail("err_ack_sb");
    n_asrt++; if (in_req_rdy !== 1'b1) fail("err_cleared");
    tick();
    n_asrt++; if (in_ack_vld !== 1'b0) fail("err_ack_drained");

    // Clear state, then fill every target to its limit
    rst_n = 1'b0;
    #1;
    n_asrt++; if (outst_cnt !== 8'h00) fail("mid_rst_cnt");
    tick();
    rst_n = 1'b1;
    in_req_vld = 1'b1; in_req_src_id = 4'd0; in_req_sideband = 32'h0;
    for (int i = 0; i < 8; i++) begin
      in_req_tgt_id = 4'(i / 2);
      #1;
      n_asrt++; if (in_req_rdy !== 1'b1) fail("fill_rdy");
      tick();
    end
    in_req_vld = 1'b0;
    #1;
    n_asrt++; if (outst_cnt !== 8'hAA) fail("fill_cnt");

    // Round-robin over four continuously valid acks
    for (int p = 0; p < N; p++) out_ack_data[p*DW +: DW] = 32'hA0 + 32'(p);
    out_ack_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_asrt++; if (out_ack_rdy !== 4'(1 << (k % 4))) fail("rr_gnt");
      if (k > 0) begin
        n_asrt++; if (in_ack_data !== 32'hA0 + 32'((k - 1) % 4)) fail("rr_data");
      end
      tick();
    end
    in_ack_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_asrt++; if (out_ack_rdy !== 4'b0000) fail("stall_rdy");
      n_asrt++; if (in_ack_vld !== 1'b1) fail("stall_vld");
      n_asrt++; if (in_ack_data !== 32'hA0) fail("stall_data");
      tick();
    end
    out_ack_vld = 4'b0000; in_ack_rdy = 1'b1;
    #1;
    n_asrt++; if (in_ack_data !== 32'hA0) fail("stall_release_data");
    tick();
    n_asrt++; if (in_ack_vld !== 1'b0) fail("rr_drained");
    n_asrt++; if (outst_cnt !== 8'h54) fail("rr_cnt");

    // Simultaneous request and ack on target 0
    in_req_vld = 1'b1; in_req_tgt_id = 4'd0;
    #1;
    n_asrt++; if (in_req_rdy !== 1'b1) fail("sim_pre_rdy");
    tick();
    out_ack_vld = 4'b0001;
    #1;
    n_asrt++; if (out_req_vld !== 4'b0001) fail("sim_req_vld");
    n_asrt++; if (out_ack_rdy !== 4'b0001) fail("sim_ack_rdy");
    tick();
    in_req_vld = 1'b0; out_ack_vld = 4'b0000;
    #1;
    n_asrt++; if (outst_cnt !== 8'h55) fail("sim_cnt");
    n_asrt++; if (in_ack_vld !== 1'b1) fail("sim_in_ack_vld");
    tick();

    // Asynchronous reset with target 2 full and an ack held
    in_req_vld = 1'b1; in_req_tgt_id = 4'd2; out_ack_vld = 4'b1000; in_ack_rdy = 1'b0;
    #1;
    n_asrt++; if (out_ack_rdy !== 4'b1000) fail("ar_ack_rdy");
    tick();
    in_req_vld = 1'b0; out_ack_vld = 4'b0000;
    #1;
    n_asrt++; if (outst_cnt !== 8'h25) fail("ar_pre_cnt");
    n_asrt++; if (in_ack_vld !== 1'b1) fail("ar_pre_ack");
    #1;
    rst_n = 1'b0;
    #1;
    n_asrt++; if (out_req_vld !== 4'b0000) fail("ar_req_vld");
    n_asrt++; if (in_ack_vld !== 1'b0) fail("ar_ack_vld");
    n_asrt++; if (in_ack_data !== 32'h0) fail("ar_ack_data");
    n_asrt++; if (in_ack_opcode !== 1'b0) fail("ar_ack_opc");
    n_asrt++; if (outst_cnt !== 8'h00) fail("ar_cnt");
    tick();
    rst_n = 1'b1; in_ack_rdy = 1'b1;
    in_req_vld = 1'b1; in_req_tgt_id = 4'd2;
    #1;
    n_asrt++; if (in_req_rdy !== 1'b1) fail("ar_post_rdy");
    n_asrt++; if (out_req_vld !== 4'b0100) fail("ar_post_vld");
    tick();
    in_req_vld = 1'b0;
    #1;
    n_asrt++; if (outst_cnt !== 8'h10) fail("ar_post_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
